trans_fifo: RTL

- Parametrised successor to the single-register trans stage: a buffered, flow-controlled pass-through from the rx side (rxd/rx_dv) to the tx side (txd/tx_en).
- Adds configurable depth, consumer backpressure (tx_rdy), occupancy/status flags and overflow accounting.
- Sits between an rx-style source with no backpressure and a tx-style sink that may stall; it is the DUT for the next-generation UVM trans environment.

---
 rtl/trans_pkg.sv | 23 ++
 rtl/trans_fifo_ram.sv | 23 ++
 rtl/trans_fifo.sv | 119 +++++++++++
 3 files changed

// File: rtl/trans_pkg.sv
// Shared constants, payload type and sizing helpers for the trans_fifo slice.
package trans_pkg;

  localparam int unsigned TRANS_DW   = 8;
  localparam int unsigned DROP_CNT_W = 16;
  localparam int unsigned XFER_CNT_W = 32;

  // Default-width payload word, used by the verification environment.
  typedef struct packed {
    logic [TRANS_DW-1:0] d;
  } trans_word_t;

  // Occupancy width: counts 0..depth inclusive.
  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Address width of the backing RAM (depth-1 entries, at least one bit).
  function automatic int unsigned ram_aw(input int unsigned depth);
    return (depth > 2) ? $clog2(depth - 1) : 1;
  endfunction

endpackage

// File: rtl/trans_fifo_ram.sv
// Simple dual-port storage: registered write, combinational read, no reset.
module trans_fifo_ram #(
  parameter int unsigned DW = 8,
  parameter int unsigned N  = 15,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/trans_fifo.sv
// Buffered rx->tx pass-through with show-ahead output register and overflow flag.
// Optional counters drop_cnt/xfer_cnt when TRANS_FIFO_STATS_EN is defined.
module trans_fifo
  import trans_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AF_TH = DEPTH - 2
) (
  input  logic                    clk,
  input  logic                    rst_en,
  input  logic                    en,
  input  logic [DW-1:0]           rxd,
  input  logic                    rx_dv,
  input  logic                    tx_rdy,
  output logic [DW-1:0]           txd,
  output logic                    tx_en,
  output logic                    full,
  output logic                    almost_full,
  output logic                    empty,
  output logic [lvl_w(DEPTH)-1:0] level,
  output logic                    ovf
`ifdef TRANS_FIFO_STATS_EN
  ,
  output logic [DROP_CNT_W-1:0]   drop_cnt,
  output logic [XFER_CNT_W-1:0]   xfer_cnt
`endif
);

  localparam int unsigned   LW       = lvl_w(DEPTH);
  localparam int unsigned   AW       = ram_aw(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 2);

  logic          push, pop, drop;
  logic          ram_empty, direct, ram_wr, ram_rd;
  logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [DW-1:0] ram_rdata;
  logic [LW-1:0] level_nxt;

  // Pointers wrap over the DEPTH-1 RAM entries, which need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + AW'(1);
  endfunction

  assign full        = (level == LW'(DEPTH));
  assign almost_full = (level >= LW'(AF_TH));
  assign empty       = (level == '0);

  // The output register always fills first, so level<=1 means the RAM is empty.
  always_comb begin
    push       = en && rx_dv && !full;
    drop       = en && rx_dv && full;
    pop        = en && tx_en && tx_rdy;
    ram_empty  = (level <= LW'(1));
    direct     = push && ram_empty && (!tx_en || pop);
    ram_wr     = push && !direct;
    ram_rd     = pop && !ram_empty;
    wr_ptr_nxt = ram_wr ? ptr_inc(wr_ptr) : wr_ptr;
    rd_ptr_nxt = ram_rd ? ptr_inc(rd_ptr) : rd_ptr;
    level_nxt  = level;
    case ({push, pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  trans_fifo_ram #(
    .DW(DW),
    .N (DEPTH - 1),
    .AW(AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_wr),
    .waddr(wr_ptr),
    .wdata(rxd),
    .raddr(rd_ptr),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or posedge rst_en) begin
    if (rst_en) begin
      txd    <= '0;
      tx_en  <= 1'b0;
      level  <= '0;
      ovf    <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      level  <= level_nxt;
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      if (drop) ovf <= 1'b1;
      // Refill from RAM head, else bypass the incoming word, else go invalid; txd keeps its value.
      if (ram_rd) begin
        txd   <= ram_rdata;
        tx_en <= 1'b1;
      end else if (direct) begin
        txd   <= rxd;
        tx_en <= 1'b1;
      end else if (pop) begin
        tx_en <= 1'b0;
      end
    end
  end

`ifdef TRANS_FIFO_STATS_EN
  always_ff @(posedge clk or posedge rst_en) begin
    if (rst_en) begin
      drop_cnt <= '0;
      xfer_cnt <= '0;
    end else begin
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      if (pop) xfer_cnt <= xfer_cnt + XFER_CNT_W'(1);
    end
  end
`endif

endmodule
